// File: rtl/boot_ram_loader_if.sv
// rtl/boot_ram_loader_if.sv - byte stream in and RAM write port out of the boot RAM loader
interface boot_ram_loader_if #(
    parameter int AW = 14
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [7:0]    mem_din;

    // Stream source and RAM side (bench or upstream logic)
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_a,
        input  mem_din
    );

    // Loader side
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_a,
        output mem_din
    );
endinterface

// File: rtl/boot_ram_loader.sv
// rtl/boot_ram_loader.sv - streams a checksummed byte image into the boot ROM RAM
module boot_ram_loader #(
    parameter int DEPTH = 9216,
    parameter int AW    = 14
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [AW-1:0]       start_addr,
    input  logic [AW:0]         length,
    input  logic                abort,
    boot_ram_loader_if.slave    bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_FIN
    } state_t;

    // Two spare bits so start_addr + length can never wrap before the range compare
    localparam logic [AW+1:0] DEPTH_X = (AW+2)'(DEPTH);

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] addr;
    logic [AW:0]   remain;
    logic [7:0]    sum;
    logic [1:0]    code;
    logic          mem_we_q;
    logic [AW-1:0] mem_a_q;
    logic [7:0]    mem_din_q;

    logic [AW+1:0] end_addr;
    logic          range_bad;
    logic          active;
    logic          ready;
    logic          xfer;
    logic [7:0]    sum_nx;

    assign end_addr  = {2'b00, start_addr} + {1'b0, length};
    assign range_bad = (length == '0) || (end_addr > DEPTH_X);
    assign active    = (state == S_LOAD) || (state == S_CHECK);
    assign ready     = active && !abort;
    assign xfer      = ready && bus.in_valid;
    assign sum_nx    = sum + bus.in_data;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state selection; abort takes priority over any offered byte
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = range_bad ? S_FIN : S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_nx = S_FIN;
                end else if (xfer && (remain == {{AW{1'b0}}, 1'b1})) begin
                    state_nx = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort || xfer) begin
                    state_nx = S_FIN;
                end
            end
            S_FIN: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Address/count/sum tracking, error code and the registered RAM write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            remain    <= '0;
            sum       <= '0;
            code      <= 2'b00;
            mem_we_q  <= 1'b0;
            mem_a_q   <= '0;
            mem_din_q <= '0;
        end else begin
            mem_we_q <= (state == S_LOAD) && xfer;
            if ((state == S_IDLE) && start) begin
                code   <= range_bad ? 2'b10 : 2'b00;
                addr   <= start_addr;
                remain <= length;
                sum    <= '0;
            end else if (active && abort) begin
                code <= 2'b11;
            end else if ((state == S_LOAD) && xfer) begin
                mem_a_q   <= addr;
                mem_din_q <= bus.in_data;
                addr      <= addr + 1'b1;
                remain    <= remain - 1'b1;
                sum       <= sum_nx;
            end else if ((state == S_CHECK) && xfer && (sum_nx != 8'd0)) begin
                code <= 2'b01;
            end
        end
    end

    assign bus.in_ready = ready;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_a    = mem_a_q;
    assign bus.mem_din  = mem_din_q;
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_FIN);
    assign err_code     = code;
    assign err          = (code != 2'b00);
endmodule

// File: tb/tb_boot_ram_loader.sv
// tb/tb_boot_ram_loader.sv - randomized self-checking bench for boot_ram_loader
module tb_boot_ram_loader;
    localparam int DEPTH = 9216;
    localparam int AW    = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   length = '0;
    logic          abort = 1'b0;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;

    boot_ram_loader_if #(.AW(AW)) bus ();

    boot_ram_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .abort      (abort),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what a loader obeying the rules must show this cycle
    bit m_busy, m_fin, m_we;
    int m_left, m_sum, m_addr, m_code, m_a, m_din;
    bit e_ready, m_xfer, m_bad;

    // Observed-side bookkeeping
    logic [7:0] ram [DEPTH];
    int wr_count, last_a, ready_seen, done_count, last_code;

    // Per-cycle compare of every output against the model, then advance the model
    always @(negedge clk) begin : compare_proc
        if (!rst_n) begin
            m_busy = 0; m_fin = 0; m_we = 0; m_left = 0; m_sum = 0;
            m_addr = 0; m_code = 0; m_a = 0; m_din = 0;
        end
        e_ready = m_busy && !m_fin && !abort;
        chk("in_ready", bus.in_ready, e_ready);
        chk("busy", busy, m_busy);
        chk("done", done, m_fin);
        chk("err_code", err_code, m_code);
        chk("err", err, m_code != 0);
        chk("mem_we", bus.mem_we, m_we);
        chk("mem_a", bus.mem_a, m_a);
        chk("mem_din", bus.mem_din, m_din);

        if (bus.mem_we === 1'b1) begin
            ram[bus.mem_a] = bus.mem_din;
            wr_count++;
            last_a = bus.mem_a;
        end
        if (bus.in_ready === 1'b1) ready_seen++;
        if (done === 1'b1) begin
            done_count++;
            last_code = err_code;
        end

        if (rst_n) begin
            m_xfer = bus.in_valid && e_ready;
            m_we = 0;
            if (m_fin) begin
                m_fin = 0;
                m_busy = 0;
            end else if (!m_busy) begin
                if (start) begin
                    m_bad = (length == 0) || (int'(start_addr) + int'(length) > DEPTH);
                    m_busy = 1;
                    if (m_bad) begin
                        m_code = 2;
                        m_fin = 1;
                    end else begin
                        m_code = 0;
                        m_left = int'(length);
                        m_sum = 0;
                        m_addr = int'(start_addr);
                    end
                end
            end else if (abort) begin
                m_code = 3;
                m_fin = 1;
            end else if (m_xfer) begin
                if (m_left > 0) begin
                    m_we = 1;
                    m_a = m_addr;
                    m_din = int'(bus.in_data);
                    m_addr++;
                    m_left--;
                    m_sum = (m_sum + int'(bus.in_data)) % 256;
                end else begin
                    if ((m_sum + int'(bus.in_data)) % 256 != 0) m_code = 1;
                    m_fin = 1;
                end
            end
        end
    end

    logic [7:0] payload [$];

    // Run one load of the queued payload; abort_after < 0 means never abort
    task automatic do_load(input int sa, input int gap_pct, input int abort_after,
                           input int ck_adj, input bit noise);
        int len, s, idx, cyc, exp_code, exp_wr;
        bit got_done, aborted, bad;
        logic [7:0] ck;
        len = payload.size();
        s = 0;
        foreach (payload[i]) s += payload[i];
        ck = 8'((256 - (s % 256)) % 256 + ck_adj);
        bad = (len == 0) || (sa + len > DEPTH);
        if (bad) begin
            exp_code = 2; exp_wr = 0;
        end else if (abort_after >= 0 && abort_after <= len) begin
            exp_code = 3; exp_wr = abort_after;
        end else begin
            exp_code = (ck_adj % 256 != 0) ? 1 : 0; exp_wr = len;
        end
        wr_count = 0; ready_seen = 0;
        idx = 0; cyc = 0; got_done = 0; aborted = 0;
        @(posedge clk); #1;
        start = 1; start_addr = AW'(sa); length = (AW+1)'(len);
        @(posedge clk); #1;
        start = 0;
        while (!got_done && cyc < 4 * len + 60) begin
            if (abort_after >= 0 && idx == abort_after && !aborted) begin
                abort = 1; bus.in_valid = 1; bus.in_data = 8'($urandom); aborted = 1;
            end else begin
                abort = 0;
                bus.in_valid = (idx <= len) && ($urandom_range(99) >= gap_pct);
                bus.in_data = (idx < len) ? payload[idx] : ck;
            end
            if (noise) begin
                start = ($urandom_range(7) == 0);
                start_addr = AW'($urandom_range(0, 200));
                length = (AW+1)'($urandom_range(1, 9));
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            if (done) got_done = 1;
            @(posedge clk); #1;
            cyc++;
        end
        start = 0; abort = 0; bus.in_valid = 0;
        chk("load_done_seen", got_done, 1);
        chk("load_err_code", last_code, exp_code);
        chk("load_write_count", wr_count, exp_wr);
        for (int i = 0; i < wr_count && i < len; i++)
            chk("ram_content", ram[sa + i], payload[i]);
    endtask

    task automatic idle_noise(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            abort = ($urandom_range(1) == 1);
        end
        @(posedge clk); #1;
        abort = 0;
    endtask

    task automatic fill_random(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
    endtask

    int dc0, sa, len;

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bus.in_valid = 0;
        bus.in_data = 0;
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_mem_a", bus.mem_a, 0);
        chk("reset_err_code", err_code, 0);
        @(posedge clk); #1 rst_n = 1;
        idle_noise(4);

        // Normal load, sum 0x0A so F6 closes it
        payload = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_load(512, 0, -1, 0, 0);
        chk("normal_code", last_code, 0);
        chk("normal_writes", wr_count, 4);
        chk("normal_ram_512", ram[512], 8'h01);
        chk("normal_ram_515", ram[515], 8'h04);

        // Same payload, checksum F7
        do_load(512, 0, -1, 1, 0);
        chk("badck_code", last_code, 1);
        chk("badck_writes", wr_count, 4);

        // One byte past the end
        fill_random(17);
        do_load(9200, 0, -1, 0, 0);
        chk("range_code", last_code, 2);
        chk("range_writes", wr_count, 0);
        chk("range_no_ready", ready_seen, 0);

        // Exactly up to the end
        fill_random(16);
        do_load(9200, 0, -1, 0, 0);
        chk("top_code", last_code, 0);
        chk("top_writes", wr_count, 16);
        chk("top_last_addr", last_a, 9215);

        // Zero length
        payload.delete();
        do_load(100, 0, -1, 0, 0);
        chk("zero_code", last_code, 2);
        chk("zero_writes", wr_count, 0);

        // 100 bytes with random gaps
        fill_random(100);
        do_load($urandom_range(0, DEPTH - 100), 50, -1, 0, 0);
        chk("gap_code", last_code, 0);
        chk("gap_writes", wr_count, 100);

        // Abort after two bytes, then a clean load
        fill_random(4);
        do_load(2000, 0, 2, 0, 0);
        chk("abort_code", last_code, 3);
        chk("abort_writes", wr_count, 2);
        fill_random(4);
        do_load(2000, 0, -1, 0, 0);
        chk("after_abort_code", last_code, 0);
        @(negedge clk);
        chk("after_abort_err", err, 0);
        idle_noise(3);

        // Reset in the middle of a load: no done pulse
        @(posedge clk); #1;
        start = 1; start_addr = 14'd300; length = 15'd8;
        @(posedge clk); #1;
        start = 0; bus.in_valid = 1; bus.in_data = 8'h5a;
        repeat (3) @(posedge clk);
        #1 rst_n = 0; bus.in_valid = 0;
        dc0 = done_count;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midreset_no_done", done_count, dc0);
        chk("midreset_idle", busy, 0);

        // Random loads: mixed ranges, gaps, aborts, bad checksums, stray starts
        for (int t = 0; t < 16; t++) begin
            len = $urandom_range(0, 40);
            if ($urandom_range(1) == 1) sa = DEPTH - 45 + $urandom_range(0, 44);
            else sa = $urandom_range(0, DEPTH - 41);
            fill_random(len);
            do_load(sa, $urandom_range(0, 60),
                    ($urandom_range(3) == 0) ? $urandom_range(0, len) : -1,
                    ($urandom_range(3) == 0) ? $urandom_range(1, 255) : 0, 1);
            idle_noise($urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
